comparator_bist_ctrl: RTL and testbench
=======================================

COMPARATOR_BIST_CTRL -- requirements
Module: comparator_bist_ctrl

Interface
REQ-001 SHALL provide parameter: LATENCY, default 2, number of register stages in the comparator under test between operand input and flag output.
REQ-002 SHALL provide port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port: RST  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: start  input  1  begins a sweep when sampled high in IDLE or DONE.
REQ-005 SHALL provide port: hold  input  1  while high in DRIVE, freezes vector issue.
REQ-006 SHALL provide ports: A_out, B_out  output  6 each  operands to the comparator.
REQ-007 SHALL provide port: S_out  output  1  mode to the comparator (0 = unsigned, 1 = signed).
REQ-008 SHALL provide ports: Equal_in, Greater_in, Smaller_in  input  1 each  comparator flags.
REQ-009 SHALL provide ports: busy, done, pass, fail_valid  output  1 each  status.
REQ-010 SHALL provide port: err_count  output  14  count of mismatching vectors.
REQ-011 SHALL provide port: first_fail  output  13  {S, A, B} of the first mismatching vector.

Function
REQ-012 SHALL implement states IDLE, DRIVE, DRAIN and DONE.
REQ-013 IDLE/DONE + start=1 -> DRIVE at the next edge; that edge SHALL clear err_count, fail_valid, first_fail and pass, and drive vector (S=0, A=0, B=0).
REQ-014 In DRIVE with hold=0, each edge SHALL advance to the next vector: B increments; B wrap 63->0 increments A; A wrap 63->0 sets S=1.
REQ-015 The sweep SHALL be exactly 8192 vectors, ending with (S=1, A=63, B=63).
REQ-016 After the last vector, the next edge SHALL enter DRAIN; DRAIN SHALL last LATENCY+1 cycles, then enter DONE.
REQ-017 hold=1 in DRIVE SHALL keep A_out/B_out/S_out unchanged and tag that cycle invalid; no vector is skipped or repeated-checked.
REQ-018 hold SHALL be ignored outside DRIVE.
REQ-019 start SHALL be ignored in DRIVE and DRAIN.
REQ-020 A vector driven at edge e SHALL have its flags sampled at edge e+LATENCY+1, using a valid/operand delay line of depth LATENCY+1.
REQ-021 Expected flags, unsigned mode: A vs B compared as 0..63.
REQ-022 Expected flags, signed mode: A vs B compared as two's complement -32..31.
REQ-023 A vector SHALL be a mismatch if the flags differ from expected, including any multi-hot or all-zero flag pattern.
REQ-024 Each mismatch SHALL increment err_count by 1, saturating at 16383 with no wrap.
REQ-025 On the first mismatch, first_fail SHALL capture {S, A, B} and fail_valid SHALL go high; both SHALL hold until the next start or RST.
REQ-026 busy SHALL be 1 in DRIVE and DRAIN and 0 otherwise.
REQ-027 done SHALL be a one-cycle pulse on DONE entry; DONE SHALL return to IDLE after one cycle unless start=1.
REQ-028 pass SHALL be set to (err_count==0), including any mismatch checked on the final DRAIN edge, on DONE entry and held until the next start or RST.
REQ-029 With hold=0 throughout, start edge to done SHALL be 8192+LATENCY+2 cycles.

Reset
REQ-030 RST=1 at an edge SHALL force IDLE from any state, including mid-sweep.
REQ-031 RST=1 at an edge SHALL clear: A_out=0, B_out=0, S_out=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0, and all delay-line valid bits.
REQ-032 RST SHALL take priority over start.

Verification
REQ-033 Ideal 2-stage comparator model, start pulse -> done after 8196 cycles, pass=1, err_count=0, fail_valid=0.
REQ-034 Greater_in stuck at 0 -> err_count=4032, first_fail=0_000001_000000, pass=0.
REQ-035 Model drives Equal=Greater=1 only on (S=1, A=5, B=5) -> err_count=1, first_fail=1_000101_000101.
REQ-036 hold=1 for 10 cycles at vector (S=0, A=3, B=7) -> outputs frozen, pass=1, completion +10 cycles.
REQ-037 start re-pulsed mid-DRIVE -> ignored; RST at vector 1000 -> all outputs at reset values next cycle, state IDLE.
REQ-038 3-stage model with LATENCY=2 -> pass=0, err_count>0.

Source files
------------

// File: rtl/comparator_bist_ctrl.sv
// rtl/comparator_bist_ctrl.sv - exhaustive BIST sweep controller for a 6-bit pipelined comparator
//
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   start                           begin a sweep (honoured in IDLE or DONE only)
//   hold                            freeze vector issue while in DRIVE
//   A_out, B_out, S_out             operands and signed-mode select to the comparator
//   Equal_in, Greater_in, Smaller_in comparator flags, LATENCY stages behind the operands
//   busy, done, pass, fail_valid    status
//   err_count                       saturating count of mismatching vectors
//   first_fail                      {S, A, B} of the first mismatching vector

module comparator_bist_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        hold,
  output logic [5:0]  A_out,
  output logic [5:0]  B_out,
  output logic        S_out,
  input  logic        Equal_in,
  input  logic        Greater_in,
  input  logic        Smaller_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail_valid,
  output logic [13:0] err_count,
  output logic [12:0] first_fail
);

  localparam int              DW         = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(LATENCY);
  localparam logic [12:0]     VEC_LAST   = 13'h1FFF;
  localparam logic [13:0]     ERR_MAX    = 14'h3FFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_start_sweep;
  logic          w_advance;

  // {S, A, B} as one counter: incrementing it walks B, carries into A, then into S.
  logic [12:0]   r_vec;
  // High for the cycle after an edge that put a fresh vector on the outputs;
  // low after a hold edge so a frozen vector is checked only once.
  logic          r_out_valid;
  logic          r_dly_v   [1:LATENCY];
  logic [12:0]   r_dly_vec [1:LATENCY];
  logic [DW-1:0] r_drain_cnt;

  logic [13:0]   r_err_count;
  logic          r_fail_valid;
  logic [12:0]   r_first_fail;
  logic          r_pass;
  logic          r_done;

  logic          w_chk_s;
  logic [5:0]    w_chk_a;
  logic [5:0]    w_chk_b;
  logic [2:0]    w_exp_flags;
  logic          w_mismatch;
  logic [13:0]   w_err_next;
  logic          w_done_entry;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_start_sweep = 1'b0;
    w_advance     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next  = ST_DRIVE;
          w_start_sweep = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!hold) begin
          if (r_vec == VEC_LAST) begin
            w_state_next = ST_DRAIN;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_next  = ST_DRIVE;
          w_start_sweep = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Checker: the vector at the end of the delay line meets the flags it produced.
  always_comb begin
    w_chk_s = r_dly_vec[LATENCY][12];
    w_chk_a = r_dly_vec[LATENCY][11:6];
    w_chk_b = r_dly_vec[LATENCY][5:0];
    if (w_chk_s) begin
      w_exp_flags = {($signed(w_chk_a) == $signed(w_chk_b)),
                     ($signed(w_chk_a) >  $signed(w_chk_b)),
                     ($signed(w_chk_a) <  $signed(w_chk_b))};
    end else begin
      w_exp_flags = {(w_chk_a == w_chk_b), (w_chk_a > w_chk_b), (w_chk_a < w_chk_b)};
    end
    // Exact compare catches multi-hot and all-zero flag patterns too.
    w_mismatch = r_dly_v[LATENCY] &&
                 ({Equal_in, Greater_in, Smaller_in} != w_exp_flags);
    if (w_mismatch && (r_err_count != ERR_MAX)) begin
      w_err_next = r_err_count + 14'd1;
    end else begin
      w_err_next = r_err_count;
    end
    w_done_entry = (r_state == ST_DRAIN) && (w_state_next == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vec        <= '0;
      r_out_valid  <= 1'b0;
      r_drain_cnt  <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
      r_done       <= 1'b0;
      for (int k = 1; k <= LATENCY; k++) begin
        r_dly_v[k]   <= 1'b0;
        r_dly_vec[k] <= '0;
      end
    end else begin
      r_done       <= w_done_entry;
      r_out_valid  <= w_start_sweep | w_advance;
      r_dly_v[1]   <= r_out_valid;
      r_dly_vec[1] <= r_vec;
      for (int k = 2; k <= LATENCY; k++) begin
        r_dly_v[k]   <= r_dly_v[k-1];
        r_dly_vec[k] <= r_dly_vec[k-1];
      end

      if (w_start_sweep) begin
        r_vec <= '0;
      end else if (w_advance) begin
        r_vec <= r_vec + 13'd1;
      end

      if ((r_state == ST_DRAIN) && (w_state_next == ST_DRAIN)) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end else begin
        r_drain_cnt <= '0;
      end

      if (w_start_sweep) begin
        r_err_count  <= '0;
        r_fail_valid <= 1'b0;
        r_first_fail <= '0;
        r_pass       <= 1'b0;
      end else begin
        r_err_count <= w_err_next;
        if (w_mismatch && !r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_first_fail <= r_dly_vec[LATENCY];
        end
        // w_err_next so a mismatch checked on this same edge still counts.
        if (w_done_entry) begin
          r_pass <= (w_err_next == 14'd0);
        end
      end
    end
  end

  assign S_out      = r_vec[12];
  assign A_out      = r_vec[11:6];
  assign B_out      = r_vec[5:0];
  assign busy       = (r_state == ST_DRIVE) || (r_state == ST_DRAIN);
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_valid = r_fail_valid;
  assign err_count  = r_err_count;
  assign first_fail = r_first_fail;

endmodule

// File: tb/tb_comparator_bist_ctrl.sv
// tb/tb_comparator_bist_ctrl.sv - directed self-checking bench for comparator_bist_ctrl

module tb_comparator_bist_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        hold;
  logic [5:0]  A_out;
  logic [5:0]  B_out;
  logic        S_out;
  logic        Equal_in;
  logic        Greater_in;
  logic        Smaller_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail_valid;
  logic [13:0] err_count;
  logic [12:0] first_fail;

  int n_total = 0;
  int n_pass  = 0;

  int mdl_lat   = 2;
  int mdl_fault = 0;

  comparator_bist_ctrl #(.LATENCY(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .hold       (hold),
    .A_out      (A_out),
    .B_out      (B_out),
    .S_out      (S_out),
    .Equal_in   (Equal_in),
    .Greater_in (Greater_in),
    .Smaller_in (Smaller_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_valid (fail_valid),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  always #5 CLK = ~CLK;

  // Comparator under test: operand registers, flags decoded from stage mdl_lat.
  logic [5:0] p_a [1:3];
  logic [5:0] p_b [1:3];
  logic       p_s [1:3];
  logic [5:0] m_a;
  logic [5:0] m_b;
  logic       m_s;

  always @(posedge CLK) begin
    p_a[1] <= A_out;
    p_b[1] <= B_out;
    p_s[1] <= S_out;
    for (int k = 2; k <= 3; k++) begin
      p_a[k] <= p_a[k-1];
      p_b[k] <= p_b[k-1];
      p_s[k] <= p_s[k-1];
    end
  end

  always_comb begin
    m_a = p_a[mdl_lat];
    m_b = p_b[mdl_lat];
    m_s = p_s[mdl_lat];
    Equal_in = (m_a == m_b);
    if (m_s) begin
      Greater_in = ($signed(m_a) > $signed(m_b));
      Smaller_in = ($signed(m_a) < $signed(m_b));
    end else begin
      Greater_in = (m_a > m_b);
      Smaller_in = (m_a < m_b);
    end
    if (mdl_fault == 1) begin
      Greater_in = 1'b0;
    end
    if (mdl_fault == 2 && m_s && m_a == 6'd5 && m_b == 6'd5) begin
      Equal_in   = 1'b1;
      Greater_in = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses start and runs until done; cycles counts edges from the start edge
  // (inclusive) to the edge that raises done.
  task automatic run_sweep(input int hold_len, input bit repulse, output int cycles,
                           output int frozen_errs);
    int         holding;
    bit         hold_used;
    logic [5:0] h_a;
    logic [5:0] h_b;
    logic       h_s;
    holding     = 0;
    hold_used   = 0;
    frozen_errs = 0;
    cycles      = 0;
    h_a = '0; h_b = '0; h_s = 1'b0;
    start = 1'b1;
    while (cycles < 20000) begin
      @(posedge CLK);
      #1;
      cycles++;
      start = 1'b0;
      if (done) break;
      if (repulse && cycles == 500) start = 1'b1;
      if (holding > 0) begin
        if (A_out != h_a || B_out != h_b || S_out != h_s || !busy) frozen_errs++;
        holding--;
        if (holding == 0) hold = 1'b0;
      end else if (hold_len > 0 && !hold_used && !S_out && A_out == 6'd3 && B_out == 6'd7) begin
        hold      = 1'b1;
        holding   = hold_len;
        hold_used = 1'b1;
        h_a = A_out; h_b = B_out; h_s = S_out;
      end
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  int cyc;
  int frz;

  initial begin
    RST   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_a",     A_out, 0);
    check_eq("rst_b",     B_out, 0);
    check_eq("rst_s",     S_out, 0);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_done",  done, 0);
    check_eq("rst_pass",  pass, 0);
    check_eq("rst_err",   err_count, 0);
    check_eq("rst_fv",    fail_valid, 0);
    check_eq("rst_ff",    first_fail, 0);
    RST = 1'b0;
    hold = 1'b1;
    @(posedge CLK); #1;
    check_eq("idle_hold_ignored_busy", busy, 0);
    hold = 1'b0;

    // First vectors after start
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check_eq("first_vec_busy", busy, 1);
    check_eq("first_vec_ab", {S_out, A_out, B_out}, 13'h0000);
    @(posedge CLK); #1;
    check_eq("second_vec_ab", {S_out, A_out, B_out}, 13'h0001);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;

    // Ideal comparator
    mdl_lat = 2; mdl_fault = 0;
    run_sweep(0, 0, cyc, frz);
    check_eq("ideal_cycles", cyc, 8196);
    check_eq("ideal_pass",   pass, 1);
    check_eq("ideal_err",    err_count, 0);
    check_eq("ideal_fv",     fail_valid, 0);
    check_eq("ideal_busy",   busy, 0);
    check_eq("ideal_last_vec", {S_out, A_out, B_out}, 13'h1FFF);
    @(posedge CLK); #1;
    check_eq("done_pulse_width", done, 0);
    check_eq("pass_held", pass, 1);

    // Greater stuck at 0
    mdl_fault = 1;
    run_sweep(0, 0, cyc, frz);
    check_eq("gt0_cycles", cyc, 8196);
    check_eq("gt0_err",    err_count, 4032);
    check_eq("gt0_ff",     first_fail, 13'h0040);
    check_eq("gt0_fv",     fail_valid, 1);
    check_eq("gt0_pass",   pass, 0);
    @(posedge CLK); #1;

    // Multi-hot flags on a single signed vector
    mdl_fault = 2;
    run_sweep(0, 0, cyc, frz);
    check_eq("multi_err",  err_count, 1);
    check_eq("multi_ff",   first_fail, 13'h1145);
    check_eq("multi_fv",   fail_valid, 1);
    check_eq("multi_pass", pass, 0);
    @(posedge CLK); #1;

    // Hold for 10 cycles at (S=0, A=3, B=7); start here also clears the previous failure
    mdl_fault = 0;
    run_sweep(10, 0, cyc, frz);
    check_eq("hold_cycles", cyc, 8206);
    check_eq("hold_frozen", frz, 0);
    check_eq("hold_pass",   pass, 1);
    check_eq("hold_fv_cleared", fail_valid, 0);
    check_eq("hold_ff_cleared", first_fail, 0);
    @(posedge CLK); #1;

    // Start re-pulsed mid-DRIVE is ignored
    run_sweep(0, 1, cyc, frz);
    check_eq("repulse_cycles", cyc, 8196);
    check_eq("repulse_pass",   pass, 1);
    @(posedge CLK); #1;

    // Reset at vector 1000 (A=15, B=40) with errors already counted
    mdl_fault = 1;
    start = 1'b1;
    cyc = 0;
    while (cyc < 1001) begin
      @(posedge CLK); #1;
      cyc++;
      start = 1'b0;
    end
    check_eq("v1000_vec", {S_out, A_out, B_out}, {1'b0, 6'd15, 6'd40});
    check_eq("v1000_err_nz", (err_count != 0), 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_eq("mid_rst_vec",  {S_out, A_out, B_out}, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_err",  err_count, 0);
    check_eq("mid_rst_fv",   fail_valid, 0);
    check_eq("mid_rst_ff",   first_fail, 0);
    @(posedge CLK); #1;
    check_eq("mid_rst_idle_busy", busy, 0);
    check_eq("mid_rst_idle_vec",  {S_out, A_out, B_out}, 0);

    // Reset wins over start
    RST = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; start = 1'b0;
    check_eq("rst_over_start_busy", busy, 0);

    // Comparator one stage deeper than the controller expects
    mdl_fault = 0; mdl_lat = 3;
    run_sweep(0, 0, cyc, frz);
    check_eq("lat3_cycles", cyc, 8196);
    check_eq("lat3_pass",   pass, 0);
    check_eq("lat3_err_nz", (err_count != 0), 1);
    check_eq("lat3_fv",     fail_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
